cov_bin_monitor: RTL and testbench
==================================

# cov_bin_monitor

Synthesizable response monitor for the 3-input coverage practice DUT: it samples the DUT inputs `a`, `b`, `c` and the output `z`, and records which of the 8 input combinations have been exercised. It also counts hits per combination and checks `z` against a parameterized truth table. It sits beside the DUT on the observation side, as the receiving end of the stimulus the bench drives. Status is exposed as registers so that coverage closure and response errors can be read without simulator coverage tools.

## Interface
- `TRUTH_TABLE`, default 8'hE8: expected `z` per vector. Bit *i* is the expected `z` for index *i* = {a,b,c}, with `a` as MSB. The default is the 3-input majority function.
- `CNT_W`, default 8: width of the per-bin hit counters and the error counter.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `sample_vld`  in  1: the current `a`/`b`/`c`/`z` form a valid observation.
- `a`, `b`, `c`  in  1 each: DUT inputs as observed.
- `z`  in  1: DUT output as observed.
- `clr`  in  1: synchronous clear of all statistics.
- `rd_bin`  in  3: selects the bin counter shown on `rd_cnt`.
- `rd_cnt`  out  CNT_W: hit count of bin `rd_bin`.
- `hit_map`  out  8: bit *i* is set once bin *i* has been hit.
- `cov_cnt`  out  4: number of distinct bins hit, range 0..8.
- `cov_done`  out  1: all 8 bins have been hit.
- `err`  out  1: one-cycle pulse on a response mismatch.
- `err_cnt`  out  CNT_W: total number of mismatches.
- `first_err_vld`  out  1: `first_err_vec` holds a captured vector.
- `first_err_vec`  out  3: index of the first mismatching sample.

## Operation
- **Index:** `idx = {a,b,c}`. A sample is accepted on a rising edge where `sample_vld=1` and `clr=0`.
- **State machine:** the states are EMPTY, COLLECT and DONE.
  - EMPTY → COLLECT on the first accepted sample.
  - COLLECT → DONE on the accepted sample that makes `cov_cnt` reach 8.
  - Any state → EMPTY when `clr=1`.
  - DONE is held until `clr` or reset. Sampling continues in DONE, so counters and error checking stay active.
- **Per accepted sample:**
  - `hit_map[idx]` is set to 1.
  - `cnt[idx]` is incremented, saturating at 2^CNT_W−1.
  - `cov_cnt` is incremented only if `hit_map[idx]` was 0 before this edge.
  - Mismatch when `z != TRUTH_TABLE[idx]`. A mismatch pulses `err` and increments `err_cnt`, saturating.
  - On the first mismatch since reset or `clr`, `idx` is captured into `first_err_vec` and `first_err_vld` is set. Later mismatches do not change the captured value.
- **Repeated vectors:** consecutive identical samples each count. There is no edge detection.
- **Outputs:** `cov_done` is 1 exactly when the state is DONE. `rd_cnt` is a combinational mux of the registered counters.
- **`clr` priority:** `clr` beats `sample_vld` in the same cycle. That sample is dropped and all statistics go to their reset values.
- **X on inputs:** an X on `a`/`b`/`c`/`z` while `sample_vld=1` is illegal. The bench must not drive it, and the RTL does not need to handle it.

## Timing
- **Reset values** (async, on `rst_n=0`):
  - `hit_map=0`, `cov_cnt=0`, `cov_done=0`, `err=0`, `err_cnt=0`, `first_err_vld=0`, `first_err_vec=0`.
  - All bin counters are 0, so `rd_cnt=0`.
  - The state is EMPTY.
- **Reset deassertion:** deassertion is sampled synchronously to `clk`. The first sample can be accepted on the first rising edge after `rst_n` goes high.
- **Latency:** 1 cycle. A sample accepted at edge N appears on all outputs after edge N, stable until edge N+1.
- **`err`:** high for exactly one cycle per mismatching sample. Back-to-back mismatches keep `err` high on consecutive cycles.
- **`cov_done`:** rises after the edge that accepts the 8th distinct bin.
- **Reset mid-run:** asserting reset mid-run clears everything immediately, with no dependence on `clk`.
- **`rd_bin` reads:** no wait states. A read of the bin being updated at edge N returns the pre-update value before N and the post-update value after N.

## Test plan
- **Reset check:** hold `rst_n=0` for 3 cycles, release, then idle 2 cycles → `hit_map=0`, `cov_cnt=0`, `cov_done=0`, `err_cnt=0`, `rd_cnt=0` for every `rd_bin`.
- **Full sweep:** drive indices 0..7 in order, one per cycle, with `z` equal to the majority function.
  - `cov_cnt` steps 1..8.
  - `cov_done` rises after the 8th edge.
  - `hit_map=8'hFF`, each `rd_cnt=1`, `err_cnt=0`.
- **Repeats and saturation:** with `CNT_W=4`, drive idx 5 for 20 samples → `rd_cnt`(5)=15 (saturated), `cov_cnt=1`, `hit_map=8'h20`, state COLLECT.
- **Mismatch capture:**
  - Drive idx 3 with `z=0`, then idx 6 with `z=0`.
  - `err` is high for 2 consecutive cycles and `err_cnt=2`.
  - `first_err_vld=1` and `first_err_vec=3`.
- **Clear collision:** after a full sweep, assert `clr` together with `sample_vld` (idx 2) for one cycle.
  - All statistics return to their reset values and the state is EMPTY.
  - `rd_cnt`(2)=0.
  - The next sample, idx 2, gives `cov_cnt=1`.
- **Async reset mid-sweep:** after 4 samples, pulse `rst_n` low between clock edges → outputs clear within the same cycle. The sweep then resumes from `cov_cnt=0`.

Source files
------------

// File: rtl/cov_bin_monitor.sv
// Observation-side coverage monitor for a 3-input DUT: tracks which {a,b,c} combinations
// were seen, counts hits per bin, and checks z against a truth table.
module cov_bin_monitor #(
    parameter logic [7:0]  TRUTH_TABLE = 8'hE8,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_vld,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             z,
    input  logic             clr,
    input  logic [2:0]       rd_bin,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [7:0]       hit_map,
    output logic [3:0]       cov_cnt,
    output logic             cov_done,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_err_vld,
    output logic [2:0]       first_err_vec
);

    localparam logic [1:0] StEmpty   = 2'd0;
    localparam logic [1:0] StCollect = 2'd1;
    localparam logic [1:0] StDone    = 2'd2;

    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];
    logic [7:0]       hit_map_q, hit_map_d;
    logic [3:0]       cov_cnt_q, cov_cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             first_err_vld_q, first_err_vld_d;
    logic [2:0]       first_err_vec_q, first_err_vec_d;

    logic [2:0] idx;
    logic       accept;
    logic       mismatch;
    logic       new_bin;

    assign idx      = {a, b, c};
    assign accept   = sample_vld & ~clr;
    assign mismatch = accept & (z != TRUTH_TABLE[idx]);
    assign new_bin  = accept & ~hit_map_q[idx];

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        hit_map_d       = hit_map_q;
        cov_cnt_d       = cov_cnt_q;
        err_d           = 1'b0;
        err_cnt_d       = err_cnt_q;
        first_err_vld_d = first_err_vld_q;
        first_err_vec_d = first_err_vec_q;

        if (clr) begin
            state_d         = StEmpty;
            for (int i = 0; i < 8; i++) cnt_d[i] = '0;
            hit_map_d       = '0;
            cov_cnt_d       = '0;
            err_cnt_d       = '0;
            first_err_vld_d = 1'b0;
            first_err_vec_d = '0;
        end else if (accept) begin
            hit_map_d[idx] = 1'b1;
            if (cnt_q[idx] != CntMax) cnt_d[idx] = cnt_q[idx] + CntOne;
            if (new_bin) cov_cnt_d = cov_cnt_q + 4'd1;

            if (mismatch) begin
                err_d = 1'b1;
                if (err_cnt_q != CntMax) err_cnt_d = err_cnt_q + CntOne;
                if (!first_err_vld_q) begin
                    first_err_vld_d = 1'b1;
                    first_err_vec_d = idx;
                end
            end

            case (state_q)
                StEmpty:   state_d = (new_bin && cov_cnt_q == 4'd7) ? StDone : StCollect;
                StCollect: if (new_bin && cov_cnt_q == 4'd7) state_d = StDone;
                StDone:    state_d = StDone;
                default:   state_d = StEmpty;
            endcase
        end else if (state_q == 2'd3) begin
            // Recover from the unused encoding
            state_d = StEmpty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StEmpty;
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
            hit_map_q       <= '0;
            cov_cnt_q       <= '0;
            err_q           <= 1'b0;
            err_cnt_q       <= '0;
            first_err_vld_q <= 1'b0;
            first_err_vec_q <= '0;
        end else begin
            state_q         <= state_d;
            for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
            hit_map_q       <= hit_map_d;
            cov_cnt_q       <= cov_cnt_d;
            err_q           <= err_d;
            err_cnt_q       <= err_cnt_d;
            first_err_vld_q <= first_err_vld_d;
            first_err_vec_q <= first_err_vec_d;
        end
    end

    assign rd_cnt        = cnt_q[rd_bin];
    assign hit_map       = hit_map_q;
    assign cov_cnt       = cov_cnt_q;
    assign cov_done      = (state_q == StDone);
    assign err           = err_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_vld = first_err_vld_q;
    assign first_err_vec = first_err_vec_q;

endmodule

// File: tb/tb_cov_bin_monitor.sv
// Randomized self-checking bench for cov_bin_monitor against a bin-level reference model.
module tb_cov_bin_monitor;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sample_vld = 1'b0;
    logic             a = 1'b0, b = 1'b0, c = 1'b0, z = 1'b0;
    logic             clr = 1'b0;
    logic [2:0]       rd_bin = 3'd0;
    logic [CNT_W-1:0] rd_cnt;
    logic [7:0]       hit_map;
    logic [3:0]       cov_cnt;
    logic             cov_done;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic             first_err_vld;
    logic [2:0]       first_err_vec;

    cov_bin_monitor #(
        .TRUTH_TABLE (8'hE8),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_vld    (sample_vld),
        .a             (a),
        .b             (b),
        .c             (c),
        .z             (z),
        .clr           (clr),
        .rd_bin        (rd_bin),
        .rd_cnt        (rd_cnt),
        .hit_map       (hit_map),
        .cov_cnt       (cov_cnt),
        .cov_done      (cov_done),
        .err           (err),
        .err_cnt       (err_cnt),
        .first_err_vld (first_err_vld),
        .first_err_vec (first_err_vec)
    );

    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: per-bin hit counts plus error bookkeeping
    int m_cnt [8];
    int m_err_cnt;
    bit m_err_pulse;
    bit m_first_vld;
    int m_first_vec;

    function automatic bit majority(input int idx);
        return (((idx >> 2) & 1) + ((idx >> 1) & 1) + (idx & 1)) >= 2;
    endfunction

    function automatic int m_cov();
        int n = 0;
        for (int i = 0; i < 8; i++) if (m_cnt[i] > 0) n++;
        return n;
    endfunction

    function automatic int m_map();
        int m = 0;
        for (int i = 0; i < 8; i++) if (m_cnt[i] > 0) m |= (1 << i);
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_err_cnt   = 0;
        m_err_pulse = 0;
        m_first_vld = 0;
        m_first_vec = 0;
    endtask

    task automatic model_step(input bit vld, input int idx, input bit zv, input bit clrv);
        m_err_pulse = 0;
        if (clrv) begin
            model_reset();
        end else if (vld) begin
            if (m_cnt[idx] < CNT_MAX) m_cnt[idx]++;
            if (zv != majority(idx)) begin
                m_err_pulse = 1;
                if (m_err_cnt < CNT_MAX) m_err_cnt++;
                if (!m_first_vld) begin
                    m_first_vld = 1;
                    m_first_vec = idx;
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    // Called right after an active edge; finishes before the next falling edge
    task automatic check_all(input string tag);
        #1;
        check({tag, ":hit_map"}, 32'(hit_map), 32'(m_map()));
        check({tag, ":cov_cnt"}, 32'(cov_cnt), 32'(m_cov()));
        check({tag, ":cov_done"}, 32'(cov_done), 32'(m_cov() == 8));
        check({tag, ":err"}, 32'(err), 32'(m_err_pulse));
        check({tag, ":err_cnt"}, 32'(err_cnt), 32'(m_err_cnt));
        check({tag, ":first_vld"}, 32'(first_err_vld), 32'(m_first_vld));
        check({tag, ":first_vec"}, 32'(first_err_vec), 32'(m_first_vec));
        for (int i = 0; i < 8; i++) begin
            rd_bin = 3'(i);
            #1;
            check($sformatf("%s:rd_cnt%0d", tag, i), 32'(rd_cnt), 32'(m_cnt[i]));
        end
    endtask

    task automatic step(input string tag, input bit vld, input int idx, input bit zv,
                        input bit clrv);
        @(negedge clk);
        sample_vld = vld;
        {a, b, c}  = 3'(idx);
        z          = zv;
        clr        = clrv;
        @(posedge clk);
        model_step(vld, idx, zv, clrv);
        check_all(tag);
    endtask

    task automatic sample(input string tag, input int idx);
        step(tag, 1'b1, idx, majority(idx), 1'b0);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_clear(input string tag);
        step(tag, 1'b0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        model_reset();

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle("reset0");
        idle("reset1");

        // Full sweep with correct responses
        for (int i = 0; i < 8; i++) sample($sformatf("sweep%0d", i), i);

        // Clear collides with a sample; the sample must be dropped
        step("clr_coll", 1'b1, 2, majority(2), 1'b1);
        sample("after_clr", 2);

        // Repeats and saturation on bin 5
        do_clear("clr_sat");
        for (int i = 0; i < 20; i++) sample($sformatf("sat%0d", i), 5);

        // Back-to-back mismatches
        do_clear("clr_mis");
        step("mis3", 1'b1, 3, 1'b0, 1'b0);
        step("mis6", 1'b1, 6, 1'b0, 1'b0);
        idle("mis_idle");
        step("mis1", 1'b1, 1, 1'b1, 1'b0);

        // Asynchronous reset between edges, mid-sweep
        do_clear("clr_ar");
        for (int i = 0; i < 4; i++) sample($sformatf("ar%0d", i), i);
        @(posedge clk);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check("async:hit_map", 32'(hit_map), 32'(0));
        check("async:cov_cnt", 32'(cov_cnt), 32'(0));
        check("async:err_cnt", 32'(err_cnt), 32'(0));
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) sample($sformatf("resume%0d", i), i);

        // Randomized traffic
        do_clear("clr_rnd");
        for (int n = 0; n < 300; n++) begin
            int  idx  = int'($urandom_range(7));
            bit  vld  = ($urandom_range(9) < 8);
            bit  bad  = ($urandom_range(19) < 3);
            bit  clrv = ($urandom_range(39) == 0);
            step($sformatf("rnd%0d", n), vld, idx, majority(idx) ^ bad, clrv);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
